// File: rtl/debounce_pkg.sv
// Shared defaults and elaboration-time helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 32'sd50000;
    localparam int DEF_SYNC_STAGES     = 32'sd2;
    localparam int DEF_REPEAT_DELAY    = 32'sd25000000;
    localparam int DEF_REPEAT_PERIOD   = 32'sd5000000;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 32'sd0;
        remaining = value - 32'sd1;
        while (remaining > 32'sd0) begin
            result    = result + 32'sd1;
            remaining = remaining >>> 1;
        end
        return result;
    endfunction

    function automatic int max2(input int a, input int b);
        int result;
        if (a > b) begin
            result = a;
        end else begin
            result = b;
        end
        return result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, stability filter, edge strobes and an auto-repeat
// counter that is built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int ACTIVE_LOW      = 32'sd0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic repeat_pulse,
    output logic rise_next
);

    localparam int            CW       = clog2(DEBOUNCE_CYCLES) + 32'sd1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);
    localparam logic          POL      = (ACTIVE_LOW != 32'sd0) ? 1'b1 : 1'b0;

    if ((DEBOUNCE_CYCLES < 32'sd1) || (SYNC_STAGES < 32'sd2) ||
        (REPEAT_DELAY < 32'sd1) || (REPEAT_PERIOD < 32'sd1)) begin : g_bad_cfg
        $error("debounce_channel: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   stable_s;
    logic [CW-1:0]          cnt_r;
    logic                   level_r;
    logic                   prev_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   rise_next_s;
    logic                   fall_next_s;

    // Polarity-normalise the pin and shift it through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw ^ POL};
        end
    end

    assign stable_s = sync_r[SYNC_STAGES-1];

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
        end else if (stable_s != level_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r   <= CNT_ZERO;
                level_r <= stable_s;
            end else begin
                cnt_r   <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    assign rise_next_s = level_r & ~prev_r;
    assign fall_next_s = ~level_r & prev_r;

    // Edge strobes are registered from the level and its one-cycle-old copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            prev_r <= level_r;
            rise_r <= rise_next_s;
            fall_r <= fall_next_s;
        end
    end

    assign level      = level_r;
    assign rise_pulse = rise_r;
    assign fall_pulse = fall_r;
    assign rise_next  = rise_next_s;

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int            RW          = clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)) + 32'sd1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 32'sd1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 32'sd1);
    localparam logic [RW-1:0] RCNT_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0] RCNT_ONE    = RW'(32'sd1);

    logic [RW-1:0] rcnt_r;
    logic [RW-1:0] rlast_s;
    logic          first_r;
    logic          rep_r;

    // The first interval after a press uses the long delay, later ones the period.
    always_comb begin
        if (first_r) begin
            rlast_s = DELAY_LAST;
        end else begin
            rlast_s = PERIOD_LAST;
        end
    end

    // Counting restarts on the rise-strobe edge, so rise and repeat never share a cycle.
    always_ff @(posedge clk) begin
        if (rst || !level_r) begin
            rcnt_r  <= RCNT_ZERO;
            first_r <= 1'b1;
            rep_r   <= 1'b0;
        end else if (!prev_r) begin
            rcnt_r  <= RCNT_ZERO;
            first_r <= 1'b1;
            rep_r   <= 1'b0;
        end else if (rcnt_r == rlast_s) begin
            rcnt_r  <= RCNT_ZERO;
            first_r <= 1'b0;
            rep_r   <= 1'b1;
        end else begin
            rcnt_r  <= rcnt_r + RCNT_ONE;
            rep_r   <= 1'b0;
        end
    end

    assign repeat_pulse = rep_r;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce_edge.sv
// N-channel debouncer with level, rise/fall/repeat strobes and a registered any-press strobe.
// Define DEBOUNCE_AUTOREPEAT_EN to build the per-channel auto-repeat counters.
module multi_debounce_edge
    import debounce_pkg::*;
#(
    parameter int CHANNELS        = 32'sd4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int ACTIVE_LOW      = 32'sd0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_rise
);

    logic [CHANNELS-1:0] rise_next_s;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .raw          (btn_raw[i]),
            .level        (btn_level[i]),
            .rise_pulse   (rise_pulse[i]),
            .fall_pulse   (fall_pulse[i]),
            .repeat_pulse (repeat_pulse[i]),
            .rise_next    (rise_next_s[i])
        );
    end

    // Built from the same term that loads rise_pulse, so both are high in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_rise <= 1'b0;
        end else begin
            any_rise <= |rise_next_s;
        end
    end

endmodule

// File: tb/tb_multi_debounce_edge.sv
// Scoreboard bench for multi_debounce_edge: directed steps push expected output events,
// a negedge monitor pops them and checks every cycle (pulses must be 0 when nothing is due).
module tb_multi_debounce_edge;

    localparam int CH  = 4;
    localparam int DC  = 4;
    localparam int SS  = 2;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = SS + DC - 1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        int          at;
        logic [3:0]  lvl;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  rpt;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [CH-1:0] btn_raw;
    logic [CH-1:0] btn_level;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [CH-1:0] repeat_pulse;
    logic          any_rise;

    exp_t       sbq[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    bit         mon_en = 1'b0;
    logic [3:0] exp_lvl = 4'b0000;
    logic [3:0] sb_lvl = 4'b0000;
    logic [3:0] sb_rep_mask = 4'b0000;
    int         sb_rep_next = 0;

    multi_debounce_edge #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DC),
        .SYNC_STAGES     (SS),
        .ACTIVE_LOW      (0),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .repeat_pulse (repeat_pulse),
        .any_rise     (any_rise)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Entries pushed for the same edge are merged so the queue stays one-per-edge.
    task automatic push_exp(input int at, input logic [3:0] lvl, input logic [3:0] rise,
                            input logic [3:0] fall, input logic [3:0] rpt);
        exp_t e;
        if (sbq.size() != 0 && sbq[$].at == at) begin
            e      = sbq.pop_back();
            e.lvl  = lvl;
            e.rise = e.rise | rise;
            e.fall = e.fall | fall;
            e.rpt  = e.rpt | rpt;
        end else begin
            e.at   = at;
            e.lvl  = lvl;
            e.rise = rise;
            e.fall = fall;
            e.rpt  = rpt;
        end
        sbq.push_back(e);
    endtask

    task automatic flush_rpt(input int upto);
        while (sb_rep_mask != 4'b0000 && sb_rep_next <= upto) begin
            push_exp(sb_rep_next, sb_lvl, 4'b0000, 4'b0000, sb_rep_mask);
            sb_rep_next = sb_rep_next + RP;
        end
    endtask

    // New level first sampled at edge k: level at k+LAT, strobes visible after k+LAT+1.
    task automatic expect_qual(input int k, input logic [3:0] new_lvl);
        logic [3:0] r;
        logic [3:0] f;
        r = new_lvl & ~sb_lvl;
        f = ~new_lvl & sb_lvl;
        flush_rpt(k + LAT);
        push_exp(k + LAT, new_lvl, 4'b0000, 4'b0000, 4'b0000);
        push_exp(k + LAT + 1, new_lvl, r, f, 4'b0000);
        if (AUTO) begin
            if (r != 4'b0000 && sb_rep_mask == 4'b0000) sb_rep_next = k + LAT + 1 + RD;
            sb_rep_mask = (sb_rep_mask | r) & new_lvl;
        end
        sb_lvl = new_lvl;
    endtask

    task automatic drive(input logic [3:0] raw);
        btn_raw = raw;
        expect_qual(cyc + 1, raw);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            flush_rpt(cyc + 1);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        int r_edge;
        rst    = 1'b1;
        r_edge = cyc + 1;
        flush_rpt(r_edge - 1);
        push_exp(r_edge, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        sb_lvl      = 4'b0000;
        sb_rep_mask = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        if (btn_raw != 4'b0000) expect_qual(cyc + 1, btn_raw);
    endtask

    // Monitor: compare every output against the due scoreboard entry or the idle state.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] er;
        logic [3:0] ef;
        logic [3:0] ep;
        if (mon_en) begin
            er = 4'b0000;
            ef = 4'b0000;
            ep = 4'b0000;
            while (sbq.size() != 0 && sbq[0].at < cyc) begin
                e = sbq.pop_front();
                vectors++;
                miscompares++;
                $error("FAIL stale_entry due_edge=%0d observed_edge=%0d", e.at, cyc);
            end
            if (sbq.size() != 0 && sbq[0].at == cyc) begin
                e       = sbq.pop_front();
                exp_lvl = e.lvl;
                er      = e.rise;
                ef      = e.fall;
                ep      = e.rpt;
            end
            vectors++;
            assert ({btn_level, rise_pulse, fall_pulse, repeat_pulse, any_rise} ===
                    {exp_lvl, er, ef, ep, |er})
            else begin
                miscompares++;
                $error("FAIL edge%0d lvl/rise/fall/rep/any observed=%b_%b_%b_%b_%b expected=%b_%b_%b_%b_%b",
                       cyc, btn_level, rise_pulse, fall_pulse, repeat_pulse, any_rise,
                       exp_lvl, er, ef, ep, |er);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        btn_raw = 4'b0000;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Reset state, then quiet idle cycles.
        do_reset();
        wait_cycles(4);

        // Clean press on ch0, held long enough for repeats, then released.
        drive(4'b0001);
        wait_cycles(19);
        drive(4'b0000);
        wait_cycles(10);

        // Bouncing ch1: 2-cycle glitches never qualify, final hold gives one rise.
        btn_raw[1] = 1'b1;
        wait_cycles(2);
        btn_raw[1] = 1'b0;
        wait_cycles(2);
        btn_raw[1] = 1'b1;
        wait_cycles(2);
        btn_raw[1] = 1'b0;
        wait_cycles(2);
        drive(4'b0010);
        wait_cycles(10);
        drive(4'b0000);
        wait_cycles(10);

        // Hold ch2 pressed, then release.
        drive(4'b0100);
        wait_cycles(25);
        drive(4'b0000);
        wait_cycles(10);

        // Simultaneous ch0+ch3, then reset while ch1 is mid-qualification.
        drive(4'b1001);
        wait_cycles(7);
        btn_raw[1] = 1'b1;
        wait_cycles(4);
        do_reset();
        wait_cycles(19);
        drive(4'b0000);
        wait_cycles(12);

        vectors++;
        assert (sbq.size() == 0)
        else begin
            miscompares++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
